// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared types and constants for the two-master system-bus arbiter.
//   - arb_state_t     : arbiter FSM states (IDLE, GNT1, GNT2)
//   - M1 / M2         : master identifiers as carried by msel, split_owner and last_gnt
//   - DEFAULT_TIMEOUT : default watchdog limit, in grant cycles
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } arb_state_t;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

  // Maps a master id to the state in which that master holds the bus.
  function automatic arb_state_t gnt_state(input logic id);
    return (id == M2) ? GNT2 : GNT1;
  endfunction

endpackage

// File: rtl/bus_arb_if.sv
// bus_arb_if
//   Request/grant bundle between the two bus masters, the slave-side status
//   pulses and the arbiter.
//   Request side  : m1_breq, m2_breq, bus_done, split, split_release
//   Grant side    : m1_bgrant, m2_bgrant, msel, split_pending, split_owner,
//                   bus_timeout, split_err
//   Modports:
//   - slave  : the arbiter. It samples requests and slave events, and drives grants.
//   - master : the surrounding bus. It drives requests and slave events, and observes grants.
interface bus_arb_if;

  logic m1_breq;
  logic m2_breq;
  logic bus_done;
  logic split;
  logic split_release;

  logic m1_bgrant;
  logic m2_bgrant;
  logic msel;
  logic split_pending;
  logic split_owner;
  logic bus_timeout;
  logic split_err;

  modport slave (
    input  m1_breq, m2_breq, bus_done, split, split_release,
    output m1_bgrant, m2_bgrant, msel, split_pending, split_owner,
           bus_timeout, split_err
  );

  modport master (
    output m1_breq, m2_breq, bus_done, split, split_release,
    input  m1_bgrant, m2_bgrant, msel, split_pending, split_owner,
           bus_timeout, split_err
  );

endinterface

// File: rtl/bus_arb_wdog.sv
// bus_arb_wdog
//   Loadable saturating tenure counter with a terminal flag.
//   clk, rst : bus clock and synchronous active-high reset
//   load     : clear the count to zero. This has priority over en.
//   en       : advance the count by one. The count saturates at MAX.
//   expire   : combinational. It is high when this edge advances the count onto MAX.
module bus_arb_wdog #(
  parameter int MAX = 63,
  parameter int W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(MAX);
  localparam logic [W-1:0] PRE  = W'(MAX - 1);

  logic [W-1:0] cnt;

  // expire looks one step ahead. The owner then drops the grant on the same
  // edge at which the count reaches MAX, not one cycle later.
  assign expire = en && !load && (cnt == PRE);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) assignments so that every flop samples pre-edge values.
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master arbiter for the shared system bus. It also tracks one
//   outstanding split transaction and enforces a per-tenure watchdog.
//   Parameters:
//     TIMEOUT : longest grant without bus_done/split (must be >= 4)
//   Ports:
//     clk     : bus clock (rising edge)
//     rst     : synchronous active-high reset
//     bus     : bus_arb_if.slave. Requests and slave events come in; grants,
//               msel, split status and the error/timeout pulses go out.
//               All outputs are registered.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  bus_arb_if.slave     bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t state, state_n;

  logic last_gnt, last_gnt_n;
  logic msel_q, msel_n;
  logic sp_q, sp_n;         // split_pending
  logic so_q, so_n;         // split_owner
  logic rel_q, rel_n;       // release of the parked owner already seen
  logic to_q, to_n;         // bus_timeout pulse
  logic se_q, se_n;         // split_err pulse

  logic wd_load, wd_en, wd_expire;
  logic elig1, elig2, parked1, parked2, rel_grant;
  logic cur_id, cur_req, take, win;

  bus_arb_wdog #(
    .MAX (TIMEOUT - 1),
    .W   (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .en     (wd_en),
    .expire (wd_expire)
  );

  assign wd_en = (state != IDLE);

  // A master parked by a split may not compete until its release is seen.
  assign parked1   = sp_q && (so_q == M1) && !rel_q;
  assign parked2   = sp_q && (so_q == M2) && !rel_q;
  assign elig1     = bus.m1_breq && !parked1;
  assign elig2     = bus.m2_breq && !parked2;
  assign rel_grant = sp_q && rel_q && ((so_q == M2) ? bus.m2_breq : bus.m1_breq);

  assign cur_id  = (state == GNT2);
  assign cur_req = cur_id ? bus.m2_breq : bus.m1_breq;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    state_n    = state;
    last_gnt_n = last_gnt;
    msel_n     = msel_q;
    sp_n       = sp_q;
    so_n       = so_q;
    rel_n      = rel_q;
    to_n       = 1'b0;
    se_n       = 1'b0;
    wd_load    = 1'b0;
    take       = 1'b0;
    win        = M1;

    // A release is latched in any state, but only while a split is outstanding.
    if (sp_q && bus.split_release) rel_n = 1'b1;

    case (state)
      IDLE: begin
        if (rel_grant) begin
          take  = 1'b1;
          win   = so_q;
          sp_n  = 1'b0;
          rel_n = 1'b0;
        end else if (elig1 && elig2) begin
          take = 1'b1;
          win  = ~last_gnt;
        end else if (elig1) begin
          take = 1'b1;
          win  = M1;
        end else if (elig2) begin
          take = 1'b1;
          win  = M2;
        end
        if (take) begin
          state_n    = gnt_state(win);
          last_gnt_n = win;
          msel_n     = win;
          wd_load    = 1'b1;
        end
      end

      GNT1, GNT2: begin
        // Exit priority: done, request dropped, split, watchdog.
        if (bus.bus_done || !cur_req) begin
          state_n = IDLE;
        end else if (bus.split) begin
          state_n = IDLE;
          if (!sp_q) begin
            sp_n  = 1'b1;
            so_n  = cur_id;
            rel_n = 1'b0;
          end else begin
            // A second split cannot be parked, so it ends the tenure like a done.
            se_n = 1'b1;
          end
        end else if (wd_expire) begin
          state_n = IDLE;
          to_n    = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= M2;
      msel_q   <= M1;
      sp_q     <= 1'b0;
      so_q     <= M1;
      rel_q    <= 1'b0;
      to_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state    <= state_n;
      last_gnt <= last_gnt_n;
      msel_q   <= msel_n;
      sp_q     <= sp_n;
      so_q     <= so_n;
      rel_q    <= rel_n;
      to_q     <= to_n;
      se_q     <= se_n;
    end
  end

  assign bus.m1_bgrant     = (state == GNT1);
  assign bus.m2_bgrant     = (state == GNT2);
  assign bus.msel          = msel_q;
  assign bus.split_pending = sp_q;
  assign bus.split_owner   = so_q;
  assign bus.bus_timeout   = to_q;
  assign bus.split_err     = se_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter with TIMEOUT=8.
//   Each step drives one set of inputs and queues the outputs expected after
//   the next rising edge. Those expectations are then popped and compared 1 ns
//   after that edge.
//   Output vector order: {m1_bgrant, m2_bgrant, msel, split_pending,
//   split_owner, bus_timeout, split_err}.
module tb_bus_arbiter;

  localparam int TB_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_arb_if bus ();

  bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       m1;
    logic       m2;
    logic       done;
    logic       split;
    logic       rel;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] exp_q[$];
  string      name_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [6:0] dut_out();
    return {bus.m1_bgrant, bus.m2_bgrant, bus.msel, bus.split_pending,
            bus.split_owner, bus.bus_timeout, bus.split_err};
  endfunction

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (m1g m2g msel sp so to se) at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic a, input logic b, input logic d,
                     input logic s, input logic l, input logic [6:0] e, input string n);
    vec_t v;
    v.rst = r; v.m1 = a; v.m2 = b; v.done = d; v.split = s; v.rel = l;
    v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic a, input logic b, input logic d,
                      input logic s, input logic l, input logic [6:0] e, input string n);
    logic [6:0] ex;
    string      nm;
    rst               = r;
    bus.m1_breq       = a;
    bus.m2_breq       = b;
    bus.bus_done      = d;
    bus.split         = s;
    bus.split_release = l;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %b expected <queued value>", dut_out());
    end else begin
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, dut_out(), ex);
    end
  endtask

  initial begin
    logic       own;
    logic [6:0] eg, ei;

    rst = 1'b1;
    bus.m1_breq = 1'b0; bus.m2_breq = 1'b0; bus.bus_done = 1'b0;
    bus.split = 1'b0;   bus.split_release = 1'b0;

    //   rst m1 m2 done split rel  expected    name
    add(1, 0, 0, 0, 0, 0, 7'b0000000, "reset");
    add(0, 1, 1, 0, 0, 0, 7'b1000000, "first_tie_m1");
    add(0, 1, 1, 0, 0, 0, 7'b1000000, "hold_m1_c2");
    add(0, 1, 1, 0, 0, 0, 7'b1000000, "hold_m1_c3");
    add(0, 1, 1, 1, 0, 0, 7'b0000000, "done_idle");
    add(0, 1, 1, 0, 0, 0, 7'b0110000, "rr_m2");
    add(0, 1, 1, 1, 0, 0, 7'b0010000, "done_msel_parks");
    add(0, 1, 1, 0, 0, 0, 7'b1000000, "rr_m1");
    add(0, 1, 1, 0, 1, 0, 7'b0001000, "split_m1");
    add(0, 1, 1, 0, 0, 0, 7'b0111000, "parked_m1_gnt_m2");
    add(0, 1, 1, 0, 0, 1, 7'b0111000, "release_in_m2");
    add(0, 1, 1, 0, 0, 0, 7'b0111000, "hold_m2");
    add(0, 1, 1, 1, 0, 0, 7'b0011000, "m2_done");
    add(0, 1, 1, 0, 0, 0, 7'b1000000, "released_m1_first");
    add(0, 1, 1, 0, 1, 0, 7'b0001000, "split_m1_again");
    add(0, 1, 1, 0, 0, 0, 7'b0111000, "gnt_m2_parked");
    add(0, 1, 1, 0, 1, 0, 7'b0011001, "split_err");
    add(0, 1, 1, 0, 0, 0, 7'b0111000, "m2_single_elig");
    add(0, 1, 1, 1, 1, 0, 7'b0011000, "done_beats_split_pend");
    add(0, 1, 1, 0, 0, 0, 7'b0111000, "m2_again");
    add(0, 1, 1, 0, 0, 1, 7'b0111000, "release2");
    add(0, 1, 1, 1, 0, 0, 7'b0011000, "m2_done2");
    add(0, 1, 1, 0, 0, 0, 7'b1000000, "released_m1_2");
    add(0, 1, 1, 1, 1, 0, 7'b0000000, "done_split_no_record");
    add(0, 1, 1, 0, 0, 0, 7'b0110000, "rr_after_no_split");
    add(0, 1, 1, 0, 1, 0, 7'b0011100, "split_m2");
    add(0, 1, 1, 0, 0, 0, 7'b1001100, "m1_while_m2_parked");
    add(1, 1, 1, 0, 0, 0, 7'b0000000, "rst_mid_grant");
    add(0, 1, 1, 0, 0, 0, 7'b1000000, "post_rst_tie_m1");
    add(0, 0, 1, 0, 0, 0, 7'b0000000, "breq_drop");
    add(0, 0, 0, 1, 1, 0, 7'b0000000, "idle_events_ignored");
    add(0, 0, 0, 0, 0, 1, 7'b0000000, "release_no_pending");
    add(0, 0, 1, 0, 0, 0, 7'b0110000, "single_m2");
    add(0, 0, 0, 0, 0, 0, 7'b0010000, "m2_drop");

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].m1, tbl[i].m2, tbl[i].done, tbl[i].split,
           tbl[i].rel, tbl[i].exp, tbl[i].name);

    // Alternation: both masters request continuously, and done arrives in grant cycle 4.
    for (int t = 0; t < 10; t++) begin
      own = (t % 2 == 1);
      eg  = own ? 7'b0110000 : 7'b1000000;
      ei  = own ? 7'b0010000 : 7'b0000000;
      step(0, 1, 1, 0, 0, 0, eg, "alt_grant");
      for (int k = 0; k < 3; k++) begin
        step(0, 1, 1, 0, 0, 0, eg, "alt_hold");
        check("alt_mutex", {6'b0, bus.m1_bgrant & bus.m2_bgrant}, 7'b0);
      end
      step(0, 1, 1, 1, 0, 0, ei, "alt_done");
    end

    // Watchdog: m2 holds the bus with no done. The grant drops at edge E+7 with a
    // timeout pulse, and the waiting m1 wins next.
    step(0, 0, 1, 0, 0, 0, 7'b0110000, "to_grant_m2");
    for (int k = 1; k < TB_TIMEOUT - 1; k++)
      step(0, 1, 1, 0, 0, 0, 7'b0110000, "to_hold");
    step(0, 1, 1, 0, 0, 0, 7'b0010010, "to_pulse");
    step(0, 1, 1, 0, 0, 0, 7'b1000000, "to_m1_next");
    step(0, 0, 0, 0, 0, 0, 7'b0000000, "to_m1_drop");

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
